// File: rtl/lsu_mem_ctrl.sv
// ============================================================================
// Module      : lsu_mem_ctrl
// Description : Load/store unit bridging 64-bit core accesses onto a 32-bit
//               data memory, one or two beats per access.
//               Optional LSU_MISALIGN_CHECK_EN: misaligned accesses return
//               resp_err without touching memory.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_mem_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_ren,
    output logic [63:0] mem_raddr,
    input  logic [31:0] mem_rdata,
    output logic [63:0] mem_waddr,
    output logic [31:0] mem_wdata,
    output logic [7:0]  mem_wmask
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BEAT0 = 2'd1;
    localparam logic [1:0] S_BEAT1 = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]  r_state;
    logic        r_req_ready;
    logic        r_wen;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [63:0] r_addr;
    logic [31:0] r_wdata_hi;
    logic [31:0] r_lo;
    logic        r_resp_valid;
    logic [63:0] r_resp_rdata;
    logic        r_mem_ren;
    logic [63:0] r_mem_raddr;
    logic [63:0] r_mem_waddr;
    logic [31:0] r_mem_wdata;
    logic [3:0]  r_mem_wmask;

    logic        w_hs;
    logic [63:0] w_amask;
    logic [63:0] w_addr;
    logic [63:0] w_addr_al;
    logic [4:0]  w_lsh;
    logic [31:0] w_wdata0;
    logic [3:0]  w_wmask0;
    logic [31:0] w_rsh;
    logic [63:0] w_ext;

    assign w_hs = req_valid & r_req_ready;

    // Address bits below the access size are dropped; with the check enabled
    // a nonzero drop diverts the request to an error response instead.
    always_comb begin
        w_amask = ~64'd0;
        case (req_size)
            2'd1:    w_amask = ~64'd1;
            2'd2:    w_amask = ~64'd3;
            2'd3:    w_amask = ~64'd7;
            default: w_amask = ~64'd0;
        endcase
    end

    assign w_addr    = req_addr & w_amask;
    assign w_addr_al = {w_addr[63:2], 2'b00};
    assign w_lsh     = {w_addr[1:0], 3'b000};

    always_comb begin
        w_wdata0 = req_wdata[31:0];
        w_wmask0 = 4'hF;
        case (req_size)
            2'd0: begin
                w_wdata0 = {24'd0, req_wdata[7:0]} << w_lsh;
                w_wmask0 = 4'b0001 << w_addr[1:0];
            end
            2'd1: begin
                w_wdata0 = {16'd0, req_wdata[15:0]} << w_lsh;
                w_wmask0 = 4'b0011 << w_addr[1:0];
            end
            default: begin
                w_wdata0 = req_wdata[31:0];
                w_wmask0 = 4'hF;
            end
        endcase
    end

    assign w_rsh = mem_rdata >> {r_addr[1:0], 3'b000};

    always_comb begin
        w_ext = 64'd0;
        case (r_size)
            2'd0:    w_ext = r_unsigned ? {56'd0, w_rsh[7:0]}  : {{56{w_rsh[7]}},  w_rsh[7:0]};
            2'd1:    w_ext = r_unsigned ? {48'd0, w_rsh[15:0]} : {{48{w_rsh[15]}}, w_rsh[15:0]};
            default: w_ext = r_unsigned ? {32'd0, w_rsh}       : {{32{w_rsh[31]}}, w_rsh};
        endcase
    end

`ifdef LSU_MISALIGN_CHECK_EN
    logic w_misalign;
    logic r_err;
    assign w_misalign = |(req_addr & ~w_amask);
    assign resp_err   = r_err;
`else
    assign resp_err   = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_req_ready  <= 1'b1;
            r_wen        <= 1'b0;
            r_size       <= 2'd0;
            r_unsigned   <= 1'b0;
            r_addr       <= 64'd0;
            r_wdata_hi   <= 32'd0;
            r_lo         <= 32'd0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 64'd0;
            r_mem_ren    <= 1'b0;
            r_mem_raddr  <= 64'd0;
            r_mem_waddr  <= 64'd0;
            r_mem_wdata  <= 32'd0;
            r_mem_wmask  <= 4'd0;
`ifdef LSU_MISALIGN_CHECK_EN
            r_err        <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_hs) begin
                        r_req_ready <= 1'b0;
                        r_wen       <= req_wen;
                        r_size      <= req_size;
                        r_unsigned  <= req_unsigned;
                        r_addr      <= w_addr;
                        r_wdata_hi  <= req_wdata[63:32];
`ifdef LSU_MISALIGN_CHECK_EN
                        r_err       <= w_misalign;
                        if (w_misalign) begin
                            r_state      <= S_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_rdata <= 64'd0;
                        end else
`endif
                        begin
                            r_state <= S_BEAT0;
                            if (req_wen) begin
                                r_mem_waddr <= w_addr_al;
                                r_mem_wdata <= w_wdata0;
                                r_mem_wmask <= w_wmask0;
                            end else begin
                                r_mem_ren   <= 1'b1;
                                r_mem_raddr <= w_addr_al;
                            end
                        end
                    end
                end
                S_BEAT0: begin
                    r_mem_ren   <= 1'b0;
                    r_mem_wmask <= 4'd0;
                    if (r_size == 2'd3) begin
                        r_state <= S_BEAT1;
                        r_lo    <= mem_rdata;
                        if (r_wen) begin
                            r_mem_waddr <= {r_addr[63:2], 2'b00} + 64'd4;
                            r_mem_wdata <= r_wdata_hi;
                            r_mem_wmask <= 4'hF;
                        end else begin
                            r_mem_ren   <= 1'b1;
                            r_mem_raddr <= {r_addr[63:2], 2'b00} + 64'd4;
                        end
                    end else begin
                        r_state      <= S_RESP;
                        r_resp_valid <= 1'b1;
                        r_resp_rdata <= r_wen ? 64'd0 : w_ext;
                    end
                end
                S_BEAT1: begin
                    r_mem_ren    <= 1'b0;
                    r_mem_wmask  <= 4'd0;
                    r_state      <= S_RESP;
                    r_resp_valid <= 1'b1;
                    r_resp_rdata <= r_wen ? 64'd0 : {mem_rdata, r_lo};
                end
                default: begin
                    if (resp_ready) begin
                        r_state      <= S_IDLE;
                        r_resp_valid <= 1'b0;
                        r_req_ready  <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign req_ready  = r_req_ready;
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign mem_ren    = r_mem_ren;
    assign mem_raddr  = r_mem_raddr;
    assign mem_waddr  = r_mem_waddr;
    assign mem_wdata  = r_mem_wdata;
    assign mem_wmask  = {4'd0, r_mem_wmask};

endmodule

`default_nettype wire

// File: tb/tb_lsu_mem_ctrl.sv
// ============================================================================
// Module      : tb_lsu_mem_ctrl
// Description : Directed self-checking bench for lsu_mem_ctrl; honours
//               LSU_MISALIGN_CHECK_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lsu_mem_ctrl;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_err;
    logic        mem_ren;
    logic [63:0] mem_raddr;
    logic [31:0] mem_rdata;
    logic [63:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic [7:0]  mem_wmask;

    int total = 0;
    int bad   = 0;

    lsu_mem_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_wen      (req_wen),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_ren      (mem_ren),
        .mem_raddr    (mem_raddr),
        .mem_rdata    (mem_rdata),
        .mem_waddr    (mem_waddr),
        .mem_wdata    (mem_wdata),
        .mem_wmask    (mem_wmask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic wen, input logic [1:0] size, input logic uns,
                         input logic [63:0] addr, input logic [63:0] wdata);
        req_valid    = 1'b1;
        req_wen      = wen;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_wen = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = 64'd0; req_wdata = 64'd0;
        resp_ready = 1'b1; mem_rdata = 32'd0;
        nxt(); nxt();
        chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
        chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
        chk("rst_resp_rdata", resp_rdata, 64'd0);
        chk("rst_mem_ren", {63'd0, mem_ren}, 64'd0);
        chk("rst_wmask", {56'd0, mem_wmask}, 64'd0);
        chk("rst_raddr", mem_raddr, 64'd0);
        chk("rst_waddr", mem_waddr, 64'd0);
        chk("rst_wdata", {32'd0, mem_wdata}, 64'd0);
        rst = 1'b0;
        nxt();

        // store byte 0xAB at 0x8000_0003
        issue(1'b1, 2'd0, 1'b0, 64'h8000_0003, 64'hAB);
        chk("sb_ready_n", {63'd0, req_ready}, 64'd1);
        nxt(); req_valid = 1'b0;
        chk("sb_wmask", {56'd0, mem_wmask}, 64'h08);
        chk("sb_waddr", mem_waddr, 64'h8000_0000);
        chk("sb_wdata", {32'd0, mem_wdata}, 64'hAB00_0000);
        chk("sb_ren", {63'd0, mem_ren}, 64'd0);
        chk("sb_ready_busy", {63'd0, req_ready}, 64'd0);
        nxt();
        chk("sb_wmask_off", {56'd0, mem_wmask}, 64'd0);
        chk("sb_resp_valid", {63'd0, resp_valid}, 64'd1);
        chk("sb_rdata", resp_rdata, 64'd0);
        chk("sb_err", {63'd0, resp_err}, 64'd0);
        nxt();
        chk("sb_done", {63'd0, resp_valid}, 64'd0);
        chk("sb_ready_back", {63'd0, req_ready}, 64'd1);

        // store half 0x1234 at 0x8000_0002
        issue(1'b1, 2'd1, 1'b0, 64'h8000_0002, 64'hFFFF_1234);
        nxt(); req_valid = 1'b0;
        chk("sh_wmask", {56'd0, mem_wmask}, 64'h0C);
        chk("sh_wdata", {32'd0, mem_wdata}, 64'h1234_0000);
        nxt(); nxt();

        // load signed byte at 0x8000_0002
        issue(1'b0, 2'd0, 1'b0, 64'h8000_0002, 64'd0);
        nxt(); req_valid = 1'b0;
        mem_rdata = 32'h0080_0000;
        chk("lb_ren", {63'd0, mem_ren}, 64'd1);
        chk("lb_raddr", mem_raddr, 64'h8000_0000);
        chk("lb_wmask", {56'd0, mem_wmask}, 64'd0);
        nxt();
        chk("lb_ren_off", {63'd0, mem_ren}, 64'd0);
        chk("lb_resp_valid", {63'd0, resp_valid}, 64'd1);
        chk("lb_rdata", resp_rdata, 64'hFFFF_FFFF_FFFF_FF80);
        nxt();

        // load unsigned byte at 0x8000_0002
        issue(1'b0, 2'd0, 1'b1, 64'h8000_0002, 64'd0);
        nxt(); req_valid = 1'b0;
        nxt();
        chk("lbu_rdata", resp_rdata, 64'h80);
        nxt();

        // load signed word
        issue(1'b0, 2'd2, 1'b0, 64'h8000_0004, 64'd0);
        nxt(); req_valid = 1'b0;
        mem_rdata = 32'h8765_4321;
        chk("lw_raddr", mem_raddr, 64'h8000_0004);
        nxt();
        chk("lw_rdata", resp_rdata, 64'hFFFF_FFFF_8765_4321);
        nxt();

        // load double at 0x8000_0008, response held for 5 cycles
        issue(1'b0, 2'd3, 1'b0, 64'h8000_0008, 64'd0);
        nxt(); req_valid = 1'b0;
        mem_rdata = 32'h1111_2222;
        chk("ld_raddr0", mem_raddr, 64'h8000_0008);
        chk("ld_ren0", {63'd0, mem_ren}, 64'd1);
        nxt();
        mem_rdata = 32'h3333_4444;
        resp_ready = 1'b0;
        chk("ld_raddr1", mem_raddr, 64'h8000_000C);
        chk("ld_ren1", {63'd0, mem_ren}, 64'd1);
        chk("ld_no_resp_n2", {63'd0, resp_valid}, 64'd0);
        nxt();
        mem_rdata = 32'h0;
        chk("ld_resp_valid", {63'd0, resp_valid}, 64'd1);
        chk("ld_rdata", resp_rdata, 64'h3333_4444_1111_2222);
        chk("ld_ren_off", {63'd0, mem_ren}, 64'd0);
        for (int i = 0; i < 5; i++) begin
            nxt();
            chk("hold_valid", {63'd0, resp_valid}, 64'd1);
            chk("hold_rdata", resp_rdata, 64'h3333_4444_1111_2222);
            chk("hold_ready", {63'd0, req_ready}, 64'd0);
        end
        resp_ready = 1'b1;
        nxt();
        chk("ld_released", {63'd0, resp_valid}, 64'd0);

        // half load at 0x8000_0001
        issue(1'b0, 2'd1, 1'b0, 64'h8000_0001, 64'd0);
        nxt(); req_valid = 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
        chk("mis_resp_valid", {63'd0, resp_valid}, 64'd1);
        chk("mis_err", {63'd0, resp_err}, 64'd1);
        chk("mis_rdata", resp_rdata, 64'd0);
        chk("mis_ren", {63'd0, mem_ren}, 64'd0);
        nxt();
        chk("mis_ren_after", {63'd0, mem_ren}, 64'd0);
`else
        mem_rdata = 32'h1234_BEEF;
        chk("mis_ren", {63'd0, mem_ren}, 64'd1);
        chk("mis_raddr", mem_raddr, 64'h8000_0000);
        nxt();
        chk("mis_resp_valid", {63'd0, resp_valid}, 64'd1);
        chk("mis_err", {63'd0, resp_err}, 64'd0);
        chk("mis_rdata", resp_rdata, 64'hFFFF_FFFF_FFFF_BEEF);
        nxt();
`endif

        // double store, reset during the second beat
        issue(1'b1, 2'd3, 1'b0, 64'h8000_0010, 64'h5555_6666_7777_8888);
        nxt(); req_valid = 1'b0;
        chk("sd_wmask0", {56'd0, mem_wmask}, 64'h0F);
        chk("sd_waddr0", mem_waddr, 64'h8000_0010);
        chk("sd_wdata0", {32'd0, mem_wdata}, 64'h7777_8888);
        nxt();
        chk("sd_wmask1", {56'd0, mem_wmask}, 64'h0F);
        chk("sd_waddr1", mem_waddr, 64'h8000_0014);
        chk("sd_wdata1", {32'd0, mem_wdata}, 64'h5555_6666);
        #2 rst = 1'b1;
        #1;
        chk("rb_wmask", {56'd0, mem_wmask}, 64'd0);
        chk("rb_ready", {63'd0, req_ready}, 64'd1);
        chk("rb_resp", {63'd0, resp_valid}, 64'd0);
        nxt();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            nxt();
            chk("rb_no_resp", {63'd0, resp_valid}, 64'd0);
            chk("rb_no_write", {56'd0, mem_wmask}, 64'd0);
            chk("rb_idle", {63'd0, req_ready}, 64'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/lsu_mem_ctrl.md
LSU_MEM_CTRL -- requirements
Module: lsu_mem_ctrl

Interface
REQ-001 SHALL have no parameters; all widths fixed (64-bit core side, 32-bit data memory side).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req_valid  input  1  core has a load/store request.
REQ-005 req_ready  output  1  block can accept a request.
REQ-006 req_wen  input  1  1 = store, 0 = load.
REQ-007 req_size  input  2  0 = byte, 1 = half, 2 = word, 3 = double.
REQ-008 req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-009 req_addr  input  64  byte address.
REQ-010 req_wdata  input  64  store data, right-aligned.
REQ-011 resp_valid  output  1  result available.
REQ-012 resp_ready  input  1  core takes result.
REQ-013 resp_rdata  output  64  extended load data; 0 for stores and errors.
REQ-014 resp_err  output  1  misaligned access flag.
REQ-015 mem_ren  output  1  read beat active.
REQ-016 mem_raddr  output  64  word-aligned read address.
REQ-017 mem_rdata  input  32  read data, combinationally valid in the same cycle as mem_raddr.
REQ-018 mem_waddr  output  64  word-aligned write address.
REQ-019 mem_wdata  output  32  lane-positioned write data.
REQ-020 mem_wmask  output  8  byte-enable mask; bits [7:4] always 0; nonzero only during a write beat.

Function
REQ-021 FSM states SHALL be IDLE, BEAT0, BEAT1, RESP.
REQ-022 req_ready SHALL be 1 only in IDLE; handshake = req_valid & req_ready latches all req_* fields and moves to BEAT0.
REQ-023 BEAT0 SHALL address (req_addr & ~3); BEAT1 (double only) SHALL address (req_addr & ~3) + 4; beat order low word first.
REQ-024 Load beat: mem_ren = 1, mem_rdata captured at end of the beat cycle; mem_wmask = 0.
REQ-025 Store beat: mem_wmask asserted for exactly one cycle per beat; byte: 1<<addr[1:0]; half: 3<<addr[1:0]; word/double beat: 0xF; mem_wdata = data shifted to lane 8*addr[1:0].
REQ-026 Load extraction: byte/half taken from lane addr[1:0]; extended to 64 bits by req_size and req_unsigned; word extended; double = {beat1, beat0}.
REQ-027 BEAT0 -> RESP for sizes 0-2; BEAT0 -> BEAT1 -> RESP for size 3.
REQ-028 Latency: handshake in cycle N; resp_valid first high in cycle N+2 (B/H/W) or N+3 (D).
REQ-029 RESP SHALL hold resp_valid and resp_* stable until resp_valid & resp_ready, then return to IDLE; a new request is accepted no earlier than the following cycle.
REQ-030 Outside beats: mem_ren = 0, mem_wmask = 0, addresses/data hold their last values.
REQ-031 Stores SHALL also produce a response (rdata = 0, err = 0 when aligned).

Reset
REQ-032 rst SHALL asynchronously force IDLE, req_ready = 1, resp_valid = 0, resp_rdata = 0, resp_err = 0, mem_ren = 0, mem_wmask = 0, mem_raddr = mem_waddr = 0, mem_wdata = 0.
REQ-033 rst asserted between BEAT0 and BEAT1 SHALL abandon the access; no second beat, no response.

Configuration
REQ-034 With LSU_MISALIGN_CHECK_EN defined, an address not aligned to its size (half: bit0; word: bits[1:0]; double: bits[2:0]) SHALL go IDLE -> RESP directly with resp_err = 1, rdata = 0, no memory beat and no write.
REQ-035 Without LSU_MISALIGN_CHECK_EN, the low address bits below the access size SHALL be forced to zero, and resp_err SHALL be tied 0.

Verification
REQ-036 Store byte 0xAB at 0x8000_0003 -> one cycle mem_waddr 0x8000_0000, mem_wmask 0x08, mem_wdata 0xAB00_0000; resp at N+2, rdata 0.
REQ-037 Load signed byte 0x8000_0002 with mem_rdata 0x0080_0000 -> resp_rdata 0xFFFF_FFFF_FFFF_FF80; unsigned -> 0x80.
REQ-038 Load double at 0x8000_0008, words 0x1111_2222 then 0x3333_4444 -> raddr 0x8000_0008, then 0x8000_000C; rdata 0x3333_4444_1111_2222 at N+3.
REQ-039 Hold resp_ready = 0 for 5 cycles in RESP -> resp_valid and rdata stable, req_ready = 0 throughout.
REQ-040 Half load at 0x8000_0001 -> with macro: resp_err = 1 at N+1, mem_ren never 1; without macro: access at lane 0, resp_err = 0.
REQ-041 Assert rst in BEAT1 of a double store -> mem_wmask 0 immediately, IDLE with req_ready = 1, no response emitted.
